start_text_renderer: RTL
========================

START_TEXT_RENDERER -- requirements
Module: start_text_renderer

Interface
REQ-001 Parameter TEXT_X, default 256, left pixel column of the text box.
REQ-002 Parameter TEXT_Y, default 232, top pixel row of the text box.
REQ-003 Parameter SCALE, default 1, pixel magnification; legal values are 1, 2 and 4 only.
REQ-004 Parameter NUM_CHARS, default 14, number of glyphs in the text ROM.
REQ-005 Parameter BLINK_FRAMES, default 30, frames per blink half-period; minimum 1.
REQ-006 Parameter TEXT_COLOR, default 8'hFF, RGB value driven while drawing.
REQ-007 clk  in  1  system clock; one clock, all logic on its rising edge.
REQ-008 resetN  in  1  reset, synchronous, active-low.
REQ-009 enable  in  1  high while the game is in the start screen.
REQ-010 startOfFrame  in  1  one-cycle pulse once per frame.
REQ-011 pixelX  in  11  current pixel column.
REQ-012 pixelY  in  11  current pixel row.
REQ-013 rom_data  in  8  glyph row from the text ROM; combinational response to rom_addr; bit 7 is the leftmost pixel.
REQ-014 rom_addr  out  8  text ROM address = char*16 + glyph_row.
REQ-015 drawingRequest  out  1  high when the current pixel is a lit text pixel.
REQ-016 RGBout  out  8  pixel colour.

Function
REQ-017 The text box SHALL span pixelX in [TEXT_X, TEXT_X + NUM_CHARS*8*SCALE) and pixelY in [TEXT_Y, TEXT_Y + 16*SCALE).
REQ-018 Inside the box: dx = pixelX-TEXT_X, dy = pixelY-TEXT_Y, char = dx/(8*SCALE), glyph_row = dy/SCALE, col = (dx/SCALE) mod 8. Divisions SHALL be shifts; no dividers.
REQ-019 Stage 1: rom_addr SHALL be registered from the current pixel; col and an inside flag SHALL be registered alongside it. Outside the box, rom_addr SHALL be 0 and inside SHALL be 0.
REQ-020 Stage 2: drawingRequest SHALL be registered as inside_d1 AND rom_data[7-col_d1] AND visible.
REQ-021 Total latency from pixelX/pixelY to drawingRequest SHALL be exactly 2 cycles.
REQ-022 RGBout SHALL be TEXT_COLOR when drawingRequest is 1, else 8'h00.
REQ-023 FSM states: IDLE, SHOW, BLANK. visible = (state == SHOW).
REQ-024 IDLE -> SHOW when enable is 1; blink counter cleared to 0.
REQ-025 SHOW/BLANK -> IDLE whenever enable is 0, with priority over all other transitions.
REQ-026 In SHOW/BLANK, each startOfFrame increments the blink counter. When the counter equals BLINK_FRAMES-1 it SHALL wrap to 0 and the state SHALL toggle SHOW<->BLANK.
REQ-027 If enable falls in the same cycle as startOfFrame, the next state SHALL be IDLE and the counter SHALL be 0.
REQ-028 The blink counter SHALL be wide enough for BLINK_FRAMES-1 and SHALL never exceed it.
REQ-029 Arithmetic SHALL be unsigned; pixels left of or above the box SHALL be detected by comparison before subtraction, not by underflow.

Reset
REQ-030 While resetN is 0 at a clock edge: state = IDLE, counter = 0, rom_addr = 0, inside/col pipeline registers = 0, drawingRequest = 0. RGBout consequently = 8'h00.
REQ-031 Reset asserted mid-frame or mid-blink SHALL abort immediately. After release the FSM re-enters SHOW from IDLE on the first cycle with enable = 1.

Verification
REQ-032 SCALE=1, enable=1 held, pixel (256,234), rom_data=8'hFC -> rom_addr=2 after 1 cycle; drawingRequest=1 and RGBout=8'hFF after 2 cycles.
REQ-033 SCALE=1, pixel (262,234), rom_data=8'hFC -> drawingRequest=0 (col 6, bit 1 = 0).
REQ-034 Pixel (367,247) -> rom_addr=223. Pixel (368,247) and pixel (255,240) -> rom_addr=0 and drawingRequest=0.
REQ-035 BLINK_FRAMES=30, enable=1 -> SHOW for 30 startOfFrame pulses, then BLANK (drawingRequest stuck 0) for 30 pulses, then SHOW again.
REQ-036 enable falls in the same cycle as startOfFrame -> IDLE, counter=0. Reassert enable -> SHOW with a full 30-frame half-period.
REQ-037 resetN=0 for 1 cycle during BLANK -> all outputs 0 next cycle. After release with enable=1, SHOW on the following cycle.

Source files
------------

// File: rtl/start_text_renderer.sv
// start_text_renderer
//   Draws a blinking line of 8x16 glyphs ("press start" style text) at a fixed
//   screen position, magnified by SCALE. Glyph rows come from an external
//   text ROM that answers combinationally.
//
//   Pipeline: stage 1 registers the ROM address plus the column and
//   inside-box flag for the current pixel; stage 2 registers the lit-pixel
//   decision once rom_data is available. Pixel to drawingRequest is 2 cycles.
//
//   Blink FSM: IDLE waits for enable; SHOW and BLANK alternate every
//   BLINK_FRAMES startOfFrame pulses. Dropping enable returns to IDLE at once.
//
// Ports
//   clk            system clock, rising edge
//   resetN         synchronous active-low reset
//   enable         start screen active
//   startOfFrame   one-cycle pulse per frame
//   pixelX/pixelY  current pixel (11 bits each)
//   rom_data       glyph row for rom_addr, bit 7 = leftmost pixel
//   rom_addr       char*16 + glyph_row
//   drawingRequest current pixel is a lit text pixel
//   RGBout         TEXT_COLOR while drawing, else 0
//   dbg_state_o    blink FSM state (0 IDLE, 1 SHOW, 2 BLANK)
//
// Handshake: none; all inputs are sampled every cycle, outputs are valid
// every cycle with the fixed latency above.
module start_text_renderer #(
  parameter int TEXT_X             = 256,
  parameter int TEXT_Y             = 232,
  parameter int SCALE              = 1,   // 1, 2 or 4
  parameter int NUM_CHARS          = 14,
  parameter int BLINK_FRAMES       = 30,  // >= 1
  parameter logic [7:0] TEXT_COLOR = 8'hFF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        enable,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [7:0]  rom_data,
  output logic [7:0]  rom_addr,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic [1:0]  dbg_state_o
);

  // Magnification as a shift so that every division is a wire shift.
  localparam int SHIFT = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;

  // Box bounds, one bit wider than the pixel bus so the right/bottom edge
  // cannot wrap.
  localparam logic [11:0] X_LO = 12'(TEXT_X);
  localparam logic [11:0] X_HI = 12'(TEXT_X + NUM_CHARS * 8 * SCALE);
  localparam logic [11:0] Y_LO = 12'(TEXT_Y);
  localparam logic [11:0] Y_HI = 12'(TEXT_Y + 16 * SCALE);
  localparam logic [10:0] X0   = 11'(TEXT_X);
  localparam logic [10:0] Y0   = 11'(TEXT_Y);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] blink_cnt_q;

  logic [7:0] rom_addr_q, rom_addr_d;
  logic [2:0] col_q, col_d;
  logic       inside_q, inside_d;
  logic       draw_q, draw_d;

  logic [10:0] dx, dy;
  logic        visible;

  // ---------------------------------------------------------------- stage 1
  // The bound comparisons come first; dx/dy are only meaningful when
  // inside_d is set, so their wrap for pixels left of/above the box is masked.
  always_comb begin
    inside_d   = ({1'b0, pixelX} >= X_LO) && ({1'b0, pixelX} < X_HI) &&
                 ({1'b0, pixelY} >= Y_LO) && ({1'b0, pixelY} < Y_HI);
    dx         = pixelX - X0;
    dy         = pixelY - Y0;
    rom_addr_d = 8'h00;
    col_d      = 3'd0;
    if (inside_d) begin
      rom_addr_d = 8'(((dx >> (3 + SHIFT)) << 4) + (dy >> SHIFT));
      col_d      = 3'(dx >> SHIFT);
    end
  end

  // ---------------------------------------------------------------- stage 2
  assign visible = (state_q == SHOW);
  assign draw_d  = inside_q & rom_data[3'd7 - col_q] & visible;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      rom_addr_q <= 8'h00;
      col_q      <= 3'd0;
      inside_q   <= 1'b0;
      draw_q     <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      col_q      <= col_d;
      inside_q   <= inside_d;
      draw_q     <= draw_d;
    end
  end

  // ---------------------------------------------------------------- blink FSM
  // Losing enable wins over a coincident startOfFrame.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= IDLE;
      blink_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          blink_cnt_q <= '0;
          if (enable) state_q <= SHOW;
        end
        SHOW, BLANK: begin
          if (!enable) begin
            state_q     <= IDLE;
            blink_cnt_q <= '0;
          end else if (startOfFrame) begin
            if (blink_cnt_q == CNT_MAX) begin
              blink_cnt_q <= '0;
              state_q     <= (state_q == SHOW) ? BLANK : SHOW;
            end else begin
              blink_cnt_q <= blink_cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          blink_cnt_q <= '0;
        end
      endcase
    end
  end

  assign rom_addr       = rom_addr_q;
  assign drawingRequest = draw_q;
  assign RGBout         = draw_q ? TEXT_COLOR : 8'h00;
  assign dbg_state_o    = state_q;

endmodule
